bcd_seg_scanner: RTL and testbench

BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

---
 rtl/bcd_seg_pkg.sv | 25 ++
 rtl/bcd_seg_decode.sv | 29 ++
 rtl/bcd_seg_scanner.sv | 135 +++++++++++++
 tb/tb_bcd_seg_scanner.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Segment encodings (active-high, bit 0 = a .. bit 6 = g) and the output polarity helpers.
package bcd_seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] seg_pol7(input logic [6:0] v, input bit active_low);
        return active_low ? ~v : v;
    endfunction

    function automatic logic seg_pol1(input logic v, input bit active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to 7-segment decoder; non-BCD values 10..15 show a dash with dp suppressed.
module bcd_seg_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_dp,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    always_comb begin
        o_seg = SEG_DASH;
        o_dp  = i_dp;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_dp = 1'b0;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed BCD 7-segment scanner with frame-atomic updates and anti-ghost blanking; outputs registered (1 cycle).
// Define BCD_SEG_LZB_EN to blank leading zeros (digit 0 is always shown).
module bcd_seg_scanner
    import bcd_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 12000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int              PW      = $clog2(REFRESH_DIV);
    localparam int              IW      = $clog2(DIGITS);
    localparam bit              ACT_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_XOR = {DIGITS{ACT_LOW}};

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_disp_dig;
    logic [DIGITS-1:0]     r_disp_dp;
    logic [4*DIGITS-1:0]   r_pend_dig;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend_vld;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame_done;

    logic                  w_slot_tick;
    logic                  w_frame;
    logic [3:0]            w_bcd;
    logic                  w_dp_req;
    logic [6:0]            w_dec_seg;
    logic                  w_dec_dp;
    logic                  w_slot_blank;
    logic                  w_lz_blank;
    logic [DIGITS-1:0]     w_an_sel;

    assign w_slot_tick  = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_frame      = w_slot_tick && (r_idx == IW'(DIGITS - 1));
    assign w_bcd        = r_disp_dig[{r_idx, 2'b00} +: 4];
    assign w_dp_req     = r_disp_dp[r_idx];
    assign w_slot_blank = (r_presc < PW'(BLANK_CYCLES));
    assign w_an_sel     = DIGITS'(1) << r_idx;

`ifdef BCD_SEG_LZB_EN
    logic [IW-1:0] w_msd;

    // Highest non-zero digit; all-zero collapses to 0 so digit 0 is never blanked.
    always_comb begin
        w_msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_disp_dig[4*i +: 4] != 4'd0) w_msd = IW'(i);
        end
    end
    assign w_lz_blank = (r_idx > w_msd);
`else
    assign w_lz_blank = 1'b0;
`endif

    bcd_seg_decode u_decode (
        .i_bcd (w_bcd),
        .i_dp  (w_dp_req),
        .o_seg (w_dec_seg),
        .o_dp  (w_dec_dp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Display data only changes on a frame boundary so a scan never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_dig <= '0;
            r_disp_dp  <= '0;
            r_pend_dig <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
        end else if (load && w_frame) begin
            r_disp_dig <= digits_in;
            r_disp_dp  <= dp_in;
            r_pend_vld <= 1'b0;
        end else begin
            if (w_frame && r_pend_vld) begin
                r_disp_dig <= r_pend_dig;
                r_disp_dp  <= r_pend_dp;
                r_pend_vld <= 1'b0;
            end
            if (load) begin
                r_pend_dig <= digits_in;
                r_pend_dp  <= dp_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg        <= seg_pol7(SEG_OFF, ACT_LOW);
            r_dp         <= seg_pol1(1'b0, ACT_LOW);
            r_an         <= AN_XOR;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= seg_pol7(w_lz_blank ? SEG_OFF : w_dec_seg, ACT_LOW);
            r_dp         <= seg_pol1(w_lz_blank ? 1'b0 : w_dec_dp, ACT_LOW);
            r_an         <= ((w_slot_blank || w_lz_blank) ? '0 : w_an_sel) ^ AN_XOR;
            r_frame_done <= w_frame;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-high outputs).
module tb_bcd_seg_scanner;

`ifdef BCD_SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    bcd_seg_scanner #(
        .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model: cycles since reset release, shown data, pending data.
    int          m_cyc;
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    bit          m_pv;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [15:0] din, input logic [3:0] dpin);
        int slot, phase, d, hi;
        bit boundary, lz;
        reset = rst; load = ld; digits_in = din; dp_in = dpin;
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pv = 0;
            e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            slot     = (m_cyc / 4) % 4;
            phase    = m_cyc % 4;
            boundary = (m_cyc % 16) == 15;
            d        = int'((m_disp >> (4 * slot)) & 16'hF);
            hi       = 0;
            for (int i = 0; i < 4; i++)
                if (((m_disp >> (4 * i)) & 16'hF) != 0) hi = i;
            lz    = LZB && (slot > hi);
            e_an  = (phase < 1 || lz) ? 4'b0000 : 4'(1 << slot);
            e_seg = lz ? 7'h00 : ref_seg(d);
            e_dp  = (lz || d > 9) ? 1'b0 : m_ddp[slot];
            e_fd  = boundary;
            if (ld && boundary) begin
                m_disp = din; m_ddp = dpin; m_pv = 0;
            end else begin
                if (boundary && m_pv) begin
                    m_disp = m_pend; m_ddp = m_pdp; m_pv = 0;
                end
                if (ld) begin
                    m_pend = din; m_pdp = dpin; m_pv = 1;
                end
            end
            m_cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] want_an;
        step(1'b1, 1'b1, 16'h9999, 4'hF);
        step(1'b1, 1'b1, 16'h8888, 4'hF);
        n_chk++;
        if ({an, seg, dp, frame_done} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b fd=%b, want all 0", an, seg, dp, frame_done);
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            want_an = (k % 4 == 0 || (LZB && k >= 4)) ? 4'b0000 : 4'(1 << (k / 4));
            n_chk++;
            if (an !== want_an) begin
                n_err++;
                $display("FAIL reset_scan k=%0d: an=%b want %b", k, an, want_an);
            end
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         m_cyc - 1, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_load_midframe();
        int f0, c;
        logic [6:0] want;
        f0 = m_cyc / 16;
        for (int i = 0; i < 48; i++) begin
            step(1'b0, i == 5, 16'h1234, 4'h0);
            c = m_cyc - 1;
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL midframe_model cyc=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (c % 4 == 2) begin
                case ((c / 4) % 4)
                    0: want = 7'h66;
                    1: want = 7'h4F;
                    2: want = 7'h5B;
                    default: want = 7'h06;
                endcase
                if (c / 16 == f0) want = (LZB && (c / 4) % 4 > 0) ? 7'h00 : 7'h3F;
                n_chk++;
                if (seg !== want) begin
                    n_err++;
                    $display("FAIL midframe_seg cyc=%0d: seg=%h want %h", c, seg, want);
                end
            end
        end
    endtask

    task automatic test_load_boundary();
        int c, load_c;
        bit ld;
        logic [6:0] want;
        load_c = -1;
        for (int i = 0; i < 40; i++) begin
            ld = (load_c < 0) && (m_cyc % 16 == 15);
            step(1'b0, ld, 16'h0007, 4'h0);
            c = m_cyc - 1;
            if (ld) load_c = c;
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL boundary_model cyc=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (load_c >= 0) begin
                n_chk++;
                if (dut.r_pend_vld !== 1'b0) begin
                    n_err++;
                    $display("FAIL boundary_pend cyc=%0d: pending_valid=%b want 0", c, dut.r_pend_vld);
                end
            end
            if (load_c >= 0 && c > load_c && c <= load_c + 16 && (c % 16 == 2 || c % 16 == 6)) begin
                want = (c % 16 == 2) ? 7'h07 : (LZB ? 7'h00 : 7'h3F);
                n_chk++;
                if (seg !== want) begin
                    n_err++;
                    $display("FAIL boundary_seg cyc=%0d: seg=%h want %h", c, seg, want);
                end
            end
        end
    endtask

    task automatic test_dash_dp();
        int c, f0;
        f0 = m_cyc / 16;
        for (int i = 0; i < 48; i++) begin
            step(1'b0, i == 0, 16'h00A5, 4'b0011);
            c = m_cyc - 1;
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL dash_model cyc=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (c / 16 == f0 + 2 && c % 16 == 6) begin
                n_chk++;
                if ({seg, dp} !== {7'h40, 1'b0}) begin
                    n_err++;
                    $display("FAIL dash_digit1 cyc=%0d: seg=%h dp=%b want 40/0", c, seg, dp);
                end
            end
            if (c / 16 == f0 + 2 && c % 16 == 2) begin
                n_chk++;
                if ({seg, dp} !== {7'h6D, 1'b1}) begin
                    n_err++;
                    $display("FAIL dash_digit0 cyc=%0d: seg=%h dp=%b want 6D/1", c, seg, dp);
                end
            end
        end
    endtask

    task automatic test_lzb();
        int c, f0, slot, phase;
        logic [3:0] want_an;
        logic [6:0] want_seg;
        f0 = m_cyc / 16;
        for (int i = 0; i < 48; i++) begin
            step(1'b0, i == 0, 16'h0005, 4'h0);
            c = m_cyc - 1;
            slot = (c / 4) % 4;
            phase = c % 4;
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL lzb_model cyc=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (c / 16 == f0 + 2) begin
                want_an  = (phase == 0 || (LZB && slot > 0)) ? 4'b0000 : 4'(1 << slot);
                want_seg = (slot == 0) ? 7'h6D : (LZB ? 7'h00 : 7'h3F);
                n_chk++;
                if ({an, seg} !== {want_an, want_seg}) begin
                    n_err++;
                    $display("FAIL lzb_slot cyc=%0d: an=%b seg=%h want an=%b seg=%h", c, an, seg, want_an, want_seg);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int pulses;
        for (int i = 0; i < 16 && (m_cyc % 16) != 9; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        n_chk++;
        if ({an, seg, dp, frame_done} !== 13'd0) begin
            n_err++;
            $display("FAIL midreset_state: an=%b seg=%h dp=%b fd=%b, want all 0", an, seg, dp, frame_done);
        end
        pulses = 0;
        for (int k = 0; k < 48; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL midreset_model k=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            if (k == 1) begin
                n_chk++;
                if (an !== 4'b0001) begin
                    n_err++;
                    $display("FAIL midreset_restart: an=%b want 0001", an);
                end
            end
            if (frame_done === 1'b1) begin
                pulses++;
                n_chk++;
                if (k % 16 != 15) begin
                    n_err++;
                    $display("FAIL midreset_fd_pos k=%0d: frame_done pulse, want only at k%%16==15", k);
                end
            end
        end
        n_chk++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL midreset_fd_count: pulses=%0d want 3", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            step(1'b0, $urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom));
            n_chk++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_err++;
                $display("FAIL random_model cyc=%0d: an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
                         m_cyc - 1, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        load = 1'b0;
        digits_in = '0;
        dp_in = '0;
        test_reset();
        test_load_midframe();
        test_load_boundary();
        test_dash_dp();
        test_lzb();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
